// File: rtl/tdm_pkg.sv
// Shared TDM definitions: the frame-sync state type and the slot-counter width
// helper. The transmit-side round-robin mux uses the same package.
package tdm_pkg;

  typedef enum logic {HUNT, LOCKED} tdm_sync_state_t;

  // Width of a slot index; a single-slot frame still needs one bit.
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position within the current TDM frame. It advances on each accepted
// word and wraps after the last slot. A realign forces it to 1, because the
// word that triggers a realign is itself slot 0.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  localparam int SW = slot_w(NUM_CHANNELS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          load_i,
  output logic [SW-1:0] slot_o,
  output logic          is_last_o,
  output logic          is_zero_o
);

  logic [SW-1:0] cnt_q, cnt_d;

  assign slot_o    = cnt_q;
  assign is_last_o = (cnt_q == SW'(NUM_CHANNELS - 1));
  assign is_zero_o = (cnt_q == '0);

  // Next slot: a realign takes priority over a normal advance.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = SW'(1);
    end else if (en_i) begin
      cnt_d = is_last_o ? '0 : cnt_q + SW'(1);
    end
  end

  // Slot register, cleared by the synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive de-interleaver. It finds frame alignment using din_sof, writes
// each slot word into a staging register, and publishes every complete aligned
// frame on dout with a single-cycle dout_valid strobe.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 2,
  localparam int SW = slot_w(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              din,
  input  logic                               din_valid,
  input  logic                               din_sof,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] dout,
  output logic                               dout_valid,
  output logic [NUM_CHANNELS-1:0]            ch_valid,
  output logic                               locked,
  output logic                               sync_err
);

  tdm_sync_state_t state_q, state_d;
  logic [SW-1:0]   slot;
  logic            slot_last, slot_zero, cnt_en, cnt_load;

  // The last slot is never staged: it goes straight from din to dout.
  logic [DATA_WIDTH-1:0]              staging_q [NUM_CHANNELS-1];
  logic [DATA_WIDTH-1:0]              staging_d [NUM_CHANNELS-1];
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] dout_q, dout_d;
  logic                               dout_valid_q, dout_valid_d;
  logic [NUM_CHANNELS-1:0]            ch_valid_q, ch_valid_d;
  logic                               sync_err_q, sync_err_d;

  tdm_slot_counter #(.NUM_CHANNELS(NUM_CHANNELS)) u_slot (
    .clk_i     (clk),
    .rst_ni    (rst),
    .en_i      (cnt_en),
    .load_i    (cnt_load),
    .slot_o    (slot),
    .is_last_o (slot_last),
    .is_zero_o (slot_zero)
  );

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ch_valid   = ch_valid_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCKED);

  // Alignment FSM, slot capture, and frame assembly for each accepted word.
  always_comb begin
    state_d      = state_q;
    staging_d    = staging_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    ch_valid_d   = '0;
    sync_err_d   = 1'b0;
    cnt_en       = 1'b0;
    cnt_load     = 1'b0;
    case (state_q)
      HUNT: begin
        if (din_valid && din_sof) begin
          staging_d[0]  = din;
          ch_valid_d[0] = 1'b1;
          cnt_load      = 1'b1;
          state_d       = LOCKED;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          if (din_sof) begin
            // An sof that arrives early drops the partial frame and starts a new one.
            sync_err_d    = !slot_zero;
            staging_d[0]  = din;
            ch_valid_d[0] = 1'b1;
            cnt_load      = 1'b1;
          end else if (slot_zero) begin
            // A missing sof means alignment is lost: drop the word and hunt again.
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
            cnt_en = 1'b1;
            for (int k = 0; k < NUM_CHANNELS; k++)
              if (slot == SW'(k)) ch_valid_d[k] = 1'b1;
            for (int k = 0; k < NUM_CHANNELS - 1; k++)
              if (slot == SW'(k)) staging_d[k] = din;
            if (slot_last) begin
              dout_valid_d = 1'b1;
              for (int k = 0; k < NUM_CHANNELS - 1; k++)
                dout_d[k*DATA_WIDTH +: DATA_WIDTH] = staging_q[k];
              dout_d[(NUM_CHANNELS-1)*DATA_WIDTH +: DATA_WIDTH] = din;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State, staging and output registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= HUNT;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ch_valid_q   <= '0;
      sync_err_q   <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS - 1; k++) staging_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ch_valid_q   <= ch_valid_d;
      sync_err_q   <= sync_err_d;
      staging_q    <= staging_d;
    end
  end

endmodule
